sram_march_bist: RTL and testbench

- On-chip initiator for one gf180mcu_ocd_ip_sram__sram*x8m8wm1 macro port; today the tester drives CEN/GWEN/WEN/A/D from the pads and reads Q.
- Runs a March C- test over addresses 0..last_addr, one SRAM operation per clock.
- Compares read data in a one-stage pipeline and reports pass/fail, fail count and first-failure capture.
- Instantiated once per SRAM, or once behind the shared address/data bus with the macro selected via its CEN.

---
 rtl/sram_march_bist.sv | 200 ++++++++++++++++++++
 tb/tb_sram_march_bist.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/sram_march_bist.sv
// March C- built-in self test initiator for one single-port SRAM macro port.
// One SRAM operation per clock; read data is compared one cycle after the read edge.
module sram_march_bist #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] last_addr,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [7:0]            fail_count,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [DATA_WIDTH-1:0] fail_exp,
    output logic [DATA_WIDTH-1:0] fail_act,
    output logic                  sram_cen,
    output logic                  sram_gwen,
    output logic [DATA_WIDTH-1:0] sram_wen,
    output logic [ADDR_WIDTH-1:0] sram_a,
    output logic [DATA_WIDTH-1:0] sram_d,
    input  logic [DATA_WIDTH-1:0] sram_q
);

    typedef enum logic [3:0] {
        StIdle, StM0, StM1, StM2, StM3, StM4, StM5, StCheck, StDone
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH-1:0] last_q, last_d;
    logic                  sub_q, sub_d;
    logic                  accept;

    logic                  cmp_valid_q;
    logic [DATA_WIDTH-1:0] cmp_exp_q;
    logic [ADDR_WIDTH-1:0] cmp_addr_q;
    logic                  miscmp;

    logic [7:0]            fail_count_d;
    logic [ADDR_WIDTH-1:0] fail_addr_d;
    logic [DATA_WIDTH-1:0] fail_exp_d, fail_act_d;
    logic                  pass_d;

    function automatic logic op_active(state_e s);
        return (s == StM0) || (s == StM1) || (s == StM2) ||
               (s == StM3) || (s == StM4) || (s == StM5);
    endfunction

    // sub = 0 is the read half, sub = 1 the write half of a two-op element
    function automatic logic op_write(state_e s, logic sub);
        return (s == StM0) || (sub && ((s == StM1) || (s == StM2) || (s == StM3) || (s == StM4)));
    endfunction

    function automatic logic op_ones(state_e s, logic sub);
        return (sub && ((s == StM1) || (s == StM3))) || (!sub && ((s == StM2) || (s == StM4)));
    endfunction

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        sub_d   = sub_q;
        last_d  = last_q;
        accept  = 1'b0;
        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = StM0;
                    addr_d  = '0;
                    sub_d   = 1'b0;
                    last_d  = last_addr;
                end
            end
            StM0: begin
                if (addr_q == last_q) begin
                    state_d = StM1;
                    addr_d  = '0;
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
            StM1, StM2: begin
                sub_d = ~sub_q;
                if (sub_q) begin
                    if (addr_q == last_q) begin
                        if (state_q == StM1) begin
                            state_d = StM2;
                            addr_d  = '0;
                        end else begin
                            state_d = StM3;
                            addr_d  = last_q;
                        end
                    end else begin
                        addr_d = addr_q + 1'b1;
                    end
                end
            end
            StM3, StM4: begin
                sub_d = ~sub_q;
                if (sub_q) begin
                    if (addr_q == '0) begin
                        state_d = (state_q == StM3) ? StM4 : StM5;
                        addr_d  = last_q;
                    end else begin
                        addr_d = addr_q - 1'b1;
                    end
                end
            end
            StM5: begin
                if (addr_q == '0) begin
                    state_d = StCheck;
                end else begin
                    addr_d = addr_q - 1'b1;
                end
            end
            StCheck: state_d = StDone;
            default: state_d = StIdle;
        endcase
    end

    assign miscmp = cmp_valid_q && (sram_q != cmp_exp_q);

    always_comb begin
        fail_count_d = fail_count;
        fail_addr_d  = fail_addr;
        fail_exp_d   = fail_exp;
        fail_act_d   = fail_act;
        pass_d       = pass;
        if (accept) begin
            fail_count_d = '0;
            fail_addr_d  = '0;
            fail_exp_d   = '0;
            fail_act_d   = '0;
            pass_d       = 1'b0;
        end else if (miscmp) begin
            if (fail_count != 8'hFF) fail_count_d = fail_count + 8'd1;
            if (fail_count == 8'd0) begin
                fail_addr_d = cmp_addr_q;
                fail_exp_d  = cmp_exp_q;
                fail_act_d  = sram_q;
            end
        end
        // The last M5 read is compared during CHECK, so pass uses the updated count
        if (state_q == StCheck) pass_d = (fail_count_d == 8'd0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            last_q      <= '0;
            sub_q       <= 1'b0;
            cmp_valid_q <= 1'b0;
            cmp_exp_q   <= '0;
            cmp_addr_q  <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            fail_count  <= '0;
            fail_addr   <= '0;
            fail_exp    <= '0;
            fail_act    <= '0;
            sram_cen    <= 1'b1;
            sram_gwen   <= 1'b1;
            sram_wen    <= '1;
            sram_a      <= '0;
            sram_d      <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            last_q      <= last_d;
            sub_q       <= sub_d;
            cmp_valid_q <= op_active(state_q) && !op_write(state_q, sub_q);
            cmp_exp_q   <= op_ones(state_q, sub_q) ? '1 : '0;
            cmp_addr_q  <= addr_q;
            busy        <= op_active(state_d) || (state_d == StCheck);
            done        <= (state_d == StDone);
            pass        <= pass_d;
            fail_count  <= fail_count_d;
            fail_addr   <= fail_addr_d;
            fail_exp    <= fail_exp_d;
            fail_act    <= fail_act_d;
            // SRAM pins carry the operation that state_d describes for the next cycle
            if (op_active(state_d)) begin
                sram_cen  <= 1'b0;
                sram_gwen <= !op_write(state_d, sub_d);
                sram_wen  <= op_write(state_d, sub_d) ? '0 : '1;
                sram_a    <= addr_d;
                if (op_write(state_d, sub_d)) sram_d <= op_ones(state_d, sub_d) ? '1 : '0;
            end else begin
                sram_cen  <= 1'b1;
                sram_gwen <= 1'b1;
                sram_wen  <= '1;
            end
        end
    end

endmodule

// File: tb/tb_sram_march_bist.sv
// Directed bench for sram_march_bist: behavioural 1024x8 SRAM with injectable read faults.
module tb_sram_march_bist;

    localparam int unsigned AW = 10;
    localparam int unsigned DW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] last_addr = '0;
    logic          busy, done, pass;
    logic [7:0]    fail_count;
    logic [AW-1:0] fail_addr;
    logic [DW-1:0] fail_exp, fail_act;
    logic          sram_cen, sram_gwen;
    logic [DW-1:0] sram_wen, sram_d;
    logic [AW-1:0] sram_a;
    logic [DW-1:0] sram_q = '0;

    sram_march_bist #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .last_addr  (last_addr),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .fail_count (fail_count),
        .fail_addr  (fail_addr),
        .fail_exp   (fail_exp),
        .fail_act   (fail_act),
        .sram_cen   (sram_cen),
        .sram_gwen  (sram_gwen),
        .sram_wen   (sram_wen),
        .sram_a     (sram_a),
        .sram_d     (sram_d),
        .sram_q     (sram_q)
    );

    always #5 clk = ~clk;

    // SRAM model; fault_mode 1 = bit 3 stuck-at-1 at 0x155, 2 = every word reads 0xFF
    logic [DW-1:0] mem [1024];
    int            fault_mode = 0;

    always @(posedge clk) begin
        if (!sram_cen && !sram_gwen) begin
            for (int b = 0; b < DW; b++) if (!sram_wen[b]) mem[sram_a][b] <= sram_d[b];
        end
        if (!sram_cen && sram_gwen) begin
            if (fault_mode == 2) sram_q <= 8'hFF;
            else if (fault_mode == 1 && sram_a == 10'h155) sram_q <= mem[sram_a] | 8'h08;
            else sram_q <= mem[sram_a];
        end
    end

    // Observation of presented operations, sampled mid-cycle
    int         en_cnt, busy_cnt, m0_len;
    bit         m0_bad, nz_addr;
    logic [9:0] seq;

    always @(negedge clk) begin
        if (busy) busy_cnt++;
        if (!sram_cen) begin
            if (en_cnt < m0_len && (sram_gwen || sram_a != en_cnt[AW-1:0] || sram_d != 8'h00))
                m0_bad = 1'b1;
            if (sram_a != '0) nz_addr = 1'b1;
            seq = {seq[8:0], sram_gwen};
            en_cnt++;
        end
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
        end
    endtask

    task automatic start_run(input int l);
        @(negedge clk);
        en_cnt    = 0;
        busy_cnt  = 0;
        m0_len    = l + 1;
        m0_bad    = 1'b0;
        nz_addr   = 1'b0;
        seq       = '0;
        last_addr = l[AW-1:0];
        start     = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input string tag, output int gaps);
        bit seen;
        seen = 1'b0;
        gaps = 0;
        for (int i = 0; i < 20000 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
            else if (!busy) gaps++;
        end
        check_eq({tag, "_done_seen"}, seen, 1);
    endtask

    int gaps;

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 8'h5A;
        repeat (3) @(negedge clk);
        check_eq("rst_cen", sram_cen, 1);
        check_eq("rst_gwen", sram_gwen, 1);
        check_eq("rst_wen", sram_wen, 8'hFF);
        check_eq("rst_a", sram_a, 0);
        check_eq("rst_d", sram_d, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_pass", pass, 0);
        check_eq("rst_fcnt", fail_count, 0);
        check_eq("rst_faddr", fail_addr, 0);
        check_eq("rst_fexp", fail_exp, 0);
        check_eq("rst_fact", fail_act, 0);
        rst_n = 1'b1;

        // Fault-free full array
        fault_mode = 0;
        start_run(1023);
        wait_done("t1", gaps);
        check_eq("t1_busy_cycles", busy_cnt, 10241);
        check_eq("t1_gaps", gaps, 0);
        check_eq("t1_ops", en_cnt, 10240);
        check_eq("t1_m0_order", m0_bad, 0);
        check_eq("t1_pass", pass, 1);
        check_eq("t1_fcnt", fail_count, 0);

        // Bit 3 stuck-at-1 at 0x155
        fault_mode = 1;
        start_run(1023);
        wait_done("t2", gaps);
        check_eq("t2_pass", pass, 0);
        check_eq("t2_fcnt", fail_count, 3);
        check_eq("t2_faddr", fail_addr, 10'h155);
        check_eq("t2_fexp", fail_exp, 8'h00);
        check_eq("t2_fact", fail_act, 8'h08);

        // Everything reads 0xFF: 768 miscompares saturate the counter
        fault_mode = 2;
        start_run(255);
        wait_done("t3", gaps);
        check_eq("t3_pass", pass, 0);
        check_eq("t3_fcnt", fail_count, 255);
        check_eq("t3_faddr", fail_addr, 0);
        check_eq("t3_fexp", fail_exp, 8'h00);
        check_eq("t3_fact", fail_act, 8'hFF);
        check_eq("t3_busy_cycles", busy_cnt, 2561);

        // Single-address run
        fault_mode = 0;
        start_run(0);
        wait_done("t4", gaps);
        check_eq("t4_ops", en_cnt, 10);
        check_eq("t4_seq_wr", seq, 10'b0101010101);
        check_eq("t4_addr0", nz_addr, 0);
        check_eq("t4_busy_cycles", busy_cnt, 11);
        check_eq("t4_gaps", gaps, 0);
        check_eq("t4_pass", pass, 1);
        check_eq("t4_fcnt", fail_count, 0);

        // Abort during M3 of a faulty run, then a clean L=511 run
        fault_mode = 1;
        start_run(1023);
        repeat (6000) @(negedge clk);
        check_eq("t5_pre_fcnt_nz", fail_count != 0, 1);
        rst_n = 1'b0;
        #1;
        check_eq("t5_rst_cen", sram_cen, 1);
        check_eq("t5_rst_gwen", sram_gwen, 1);
        check_eq("t5_rst_wen", sram_wen, 8'hFF);
        check_eq("t5_rst_busy", busy, 0);
        check_eq("t5_rst_done", done, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        fault_mode = 0;
        start_run(511);
        wait_done("t5", gaps);
        check_eq("t5_busy_cycles", busy_cnt, 5121);
        check_eq("t5_pass", pass, 1);
        check_eq("t5_fcnt", fail_count, 0);

        // start while busy must not restart or change L
        start_run(100);
        repeat (3) @(negedge clk);
        last_addr = 10'd5;
        start     = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done("t6", gaps);
        check_eq("t6_busy_cycles", busy_cnt, 1011);
        check_eq("t6_ops", en_cnt, 1010);
        check_eq("t6_pass", pass, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
